// File: rtl/note_tracker.sv
// Debounces the per-estimate note stream into a locked note with silence and timeout release.
// Optional adjacent-semitone hysteresis is enabled by defining NOTE_TRACKER_HYST_EN.
module note_tracker #(
  parameter int unsigned CONFIRM_COUNT  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned TIMER_W        = 17
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       note_valid,
  input  logic [3:0] note_name,
  input  logic [2:0] note_octave,
  input  logic       greater,
  output logic       stable_valid,
  output logic [3:0] stable_name,
  output logic [2:0] stable_octave,
  output logic       stable_greater,
  output logic       note_change
);

  localparam int unsigned IDX_W = 7;
`ifdef NOTE_TRACKER_HYST_EN
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif

  localparam logic [IDX_W-1:0]   SILENCE    = 7'd127;
  localparam logic [CNT_W-1:0]   CONFIRM_TH = CNT_W'(CONFIRM_COUNT);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [TIMER_W-1:0] TIMEOUT_TH = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] EXPIRE_AT  = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   locked_idx_q, locked_idx_d;
  logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
  logic [CNT_W-1:0]   cand_cnt_q, cand_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               stable_valid_q, stable_valid_d;
  logic [3:0]         stable_name_q, stable_name_d;
  logic [2:0]         stable_octave_q, stable_octave_d;
  logic               stable_greater_q, stable_greater_d;
  logic               note_change_q, note_change_d;

  logic [IDX_W-1:0]   sample_idx_c;
  logic [CNT_W-1:0]   thresh_c;
  logic [CNT_W-1:0]   cnt_upd_c;
  logic [6:0]         decoded_c;

  // Divide-by-12 over 0..95 as a compare chain; returns {octave, name}.
  function automatic logic [6:0] decode_idx(input logic [IDX_W-1:0] idx);
    logic [2:0]       oct;
    logic [IDX_W-1:0] rem;
    oct = 3'd0;
    rem = idx;
    for (int i = 1; i < 8; i++) begin
      if (idx >= IDX_W'(i * 12)) begin
        oct = 3'(i);
        rem = idx - IDX_W'(i * 12);
      end
    end
    return {oct, rem[3:0]};
  endfunction

  // Linear semitone index; any name >= 12 is silence.
  always_comb begin
    if (note_name >= 4'd12) begin
      sample_idx_c = SILENCE;
    end else begin
      sample_idx_c = IDX_W'({note_octave, 3'b000}) + IDX_W'({note_octave, 2'b00})
                   + IDX_W'(note_name);
    end
  end

  assign decoded_c = decode_idx(sample_idx_c);

`ifdef NOTE_TRACKER_HYST_EN
  logic adjacent_c;
  // Neighbouring semitones of the locked note must persist twice as long.
  always_comb begin
    adjacent_c = (state_q == LOCKED) && (sample_idx_c != SILENCE) &&
                 ((sample_idx_c == locked_idx_q + 7'd1) ||
                  (sample_idx_c + 7'd1 == locked_idx_q));
    thresh_c   = adjacent_c ? CNT_W'(2 * CONFIRM_COUNT) : CONFIRM_TH;
  end
`else
  assign thresh_c = CONFIRM_TH;
`endif

  always_comb begin
    state_d          = state_q;
    locked_idx_d     = locked_idx_q;
    cand_idx_d       = cand_idx_q;
    cand_cnt_d       = cand_cnt_q;
    timer_d          = timer_q;
    stable_valid_d   = stable_valid_q;
    stable_name_d    = stable_name_q;
    stable_octave_d  = stable_octave_q;
    stable_greater_d = stable_greater_q;
    note_change_d    = 1'b0;
    cnt_upd_c        = cand_cnt_q;

    if (note_valid) begin
      timer_d = '0;
      if (sample_idx_c == locked_idx_q) begin
        cand_cnt_d = '0;
        if (state_q == LOCKED) begin
          stable_greater_d = greater;
        end
      end else begin
        if (sample_idx_c == cand_idx_q) begin
          cnt_upd_c = (cand_cnt_q == CNT_MAX) ? cand_cnt_q : cand_cnt_q + CNT_W'(1);
        end else begin
          cand_idx_d = sample_idx_c;
          cnt_upd_c  = CNT_W'(1);
        end
        cand_cnt_d = cnt_upd_c;
        if (cnt_upd_c >= thresh_c) begin
          note_change_d = 1'b1;
          cand_cnt_d    = '0;
          cand_idx_d    = SILENCE;
          locked_idx_d  = sample_idx_c;
          if (sample_idx_c != SILENCE) begin
            state_d          = LOCKED;
            stable_valid_d   = 1'b1;
            stable_name_d    = decoded_c[3:0];
            stable_octave_d  = decoded_c[6:4];
            stable_greater_d = greater;
          end else begin
            state_d          = IDLE;
            stable_valid_d   = 1'b0;
            stable_name_d    = 4'd0;
            stable_octave_d  = 3'd0;
            stable_greater_d = 1'b0;
          end
        end
      end
    end else begin
      if (timer_q != TIMEOUT_TH) begin
        timer_d = timer_q + TIMER_W'(1);
      end
      // Release fires only on the cycle the timer first reaches the limit.
      if (timer_q == EXPIRE_AT) begin
        note_change_d    = (state_q == LOCKED);
        state_d          = IDLE;
        locked_idx_d     = SILENCE;
        cand_idx_d       = SILENCE;
        cand_cnt_d       = '0;
        stable_valid_d   = 1'b0;
        stable_name_d    = 4'd0;
        stable_octave_d  = 3'd0;
        stable_greater_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      locked_idx_q     <= SILENCE;
      cand_idx_q       <= SILENCE;
      cand_cnt_q       <= '0;
      timer_q          <= '0;
      stable_valid_q   <= 1'b0;
      stable_name_q    <= 4'd0;
      stable_octave_q  <= 3'd0;
      stable_greater_q <= 1'b0;
      note_change_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      locked_idx_q     <= locked_idx_d;
      cand_idx_q       <= cand_idx_d;
      cand_cnt_q       <= cand_cnt_d;
      timer_q          <= timer_d;
      stable_valid_q   <= stable_valid_d;
      stable_name_q    <= stable_name_d;
      stable_octave_q  <= stable_octave_d;
      stable_greater_q <= stable_greater_d;
      note_change_q    <= note_change_d;
    end
  end

  assign stable_valid   = stable_valid_q;
  assign stable_name    = stable_name_q;
  assign stable_octave  = stable_octave_q;
  assign stable_greater = stable_greater_q;
  assign note_change    = note_change_q;

endmodule

// File: tb/tb_note_tracker.sv
// Self-checking bench for note_tracker: integer behavioural model compared every cycle,
// plus literal expectations at key points. Define NOTE_TRACKER_HYST_EN to match a hysteresis build.
module tb_note_tracker;

  localparam int CONFIRM = 4;
  localparam int TO      = 100;
  localparam int SIL     = 127;
`ifdef NOTE_TRACKER_HYST_EN
  localparam int RUN_MAX = 31;
`else
  localparam int RUN_MAX = 15;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       note_valid = 1'b0;
  logic [3:0] note_name = 4'd0;
  logic [2:0] note_octave = 3'd0;
  logic       greater = 1'b0;
  logic       stable_valid;
  logic [3:0] stable_name;
  logic [2:0] stable_octave;
  logic       stable_greater;
  logic       note_change;

  int checks = 0;
  int failures = 0;

  // Model state: semitone indices as plain integers, SIL meaning none.
  int   m_locked = SIL;
  int   m_cand = SIL;
  int   m_run = 0;
  int   m_idle = 0;
  logic e_valid = 1'b0;
  int   e_name = 0;
  int   e_oct = 0;
  logic e_greater = 1'b0;
  logic e_change = 1'b0;

  always #5 clock = ~clock;

  note_tracker #(
    .CONFIRM_COUNT (CONFIRM),
    .TIMEOUT_CYCLES(TO),
    .TIMER_W       (17)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .note_valid    (note_valid),
    .note_name     (note_name),
    .note_octave   (note_octave),
    .greater       (greater),
    .stable_valid  (stable_valid),
    .stable_name   (stable_name),
    .stable_octave (stable_octave),
    .stable_greater(stable_greater),
    .note_change   (note_change)
  );

  task automatic model_clear_outputs();
    e_valid   = 1'b0;
    e_name    = 0;
    e_oct     = 0;
    e_greater = 1'b0;
  endtask

  task automatic model_sample(input int nm, input int oc, input logic gr);
    int idx;
    int need;
    idx = (nm >= 12) ? SIL : oc * 12 + nm;
    m_idle = 0;
    if (idx == m_locked) begin
      m_run = 0;
      if (m_locked != SIL) e_greater = gr;
    end else begin
      if (idx == m_cand) begin
        m_run = (m_run < RUN_MAX) ? m_run + 1 : m_run;
      end else begin
        m_cand = idx;
        m_run  = 1;
      end
      need = CONFIRM;
`ifdef NOTE_TRACKER_HYST_EN
      if (m_locked != SIL && idx != SIL && (idx - m_locked == 1 || m_locked - idx == 1))
        need = 2 * CONFIRM;
`endif
      if (m_run >= need) begin
        m_run    = 0;
        m_cand   = SIL;
        m_locked = idx;
        e_change = 1'b1;
        if (idx == SIL) begin
          model_clear_outputs();
        end else begin
          e_valid   = 1'b1;
          e_name    = idx % 12;
          e_oct     = idx / 12;
          e_greater = gr;
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_locked = SIL;
      m_cand   = SIL;
      m_run    = 0;
      m_idle   = 0;
      e_change = 1'b0;
      model_clear_outputs();
    end else begin
      e_change = 1'b0;
      if (note_valid) begin
        model_sample(int'(note_name), int'(note_octave), greater);
      end else if (m_idle < TO) begin
        m_idle = m_idle + 1;
        if (m_idle == TO) begin
          e_change = (m_locked != SIL);
          m_locked = SIL;
          m_cand   = SIL;
          m_run    = 0;
          model_clear_outputs();
        end
      end
    end
  end

  task automatic lit(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, let the edge happen, compare on the next negedge.
  task automatic step(input logic v, input int nm, input int oc, input logic gr);
    note_valid  = v;
    note_name   = 4'(nm);
    note_octave = 3'(oc);
    greater     = gr;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({stable_valid, stable_name, stable_octave, stable_greater, note_change} !==
        {e_valid, 4'(e_name), 3'(e_oct), e_greater, e_change}) begin
      failures++;
      $display("FAIL cycle_compare t=%0t got v=%0b n=%0d o=%0d g=%0b c=%0b want v=%0b n=%0d o=%0d g=%0b c=%0b",
               $time, stable_valid, stable_name, stable_octave, stable_greater, note_change,
               e_valid, e_name, e_oct, e_greater, e_change);
    end
  endtask

  task automatic strobes(input int n, input int nm, input int oc, input logic gr);
    for (int i = 0; i < n; i++) step(1'b1, nm, oc, gr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    @(negedge clock);
    // Reset held with strobes active.
    strobes(5, 9, 4, 1'b1);
    lit("reset_valid", int'(stable_valid), 0);
    lit("reset_name", int'(stable_name), 0);
    reset_n = 1'b1;

    // Lock A4.
    strobes(3, 9, 4, 1'b1);
    lit("prelock_valid", int'(stable_valid), 0);
    strobes(1, 9, 4, 1'b1);
    lit("lock_valid", int'(stable_valid), 1);
    lit("lock_name", int'(stable_name), 9);
    lit("lock_oct", int'(stable_octave), 4);
    lit("lock_greater", int'(stable_greater), 1);
    lit("lock_change", int'(note_change), 1);
    step(1'b1, 9, 4, 1'b0);
    lit("greater_update", int'(stable_greater), 0);
    lit("change_one_cycle", int'(note_change), 0);

    // Glitch rejection.
    step(1'b1, 11, 4, 1'b0);
    step(1'b1, 9, 4, 1'b0);
    strobes(3, 11, 4, 1'b0);
    lit("glitch_hold_name", int'(stable_name), 9);
    strobes(1, 11, 4, 1'b1);
    lit("glitch_lock_name", int'(stable_name), 11);
    lit("glitch_lock_change", int'(note_change), 1);
    strobes(4, 9, 4, 1'b0);

    // Silence release, then repeated silence stays quiet.
    strobes(4, 13, 6, 1'b0);
    lit("silence_valid", int'(stable_valid), 0);
    lit("silence_oct", int'(stable_octave), 0);
    lit("silence_change", int'(note_change), 1);
    strobes(10, 13, 6, 1'b0);
    lit("silence_no_pulse", int'(note_change), 0);

    // Timeout exactly TO cycles after the last strobe.
    strobes(4, 0, 3, 1'b0);
    lit("c3_name", int'(stable_name), 0);
    lit("c3_oct", int'(stable_octave), 3);
    idle(TO - 1);
    lit("pre_timeout_valid", int'(stable_valid), 1);
    idle(1);
    lit("timeout_valid", int'(stable_valid), 0);
    lit("timeout_change", int'(note_change), 1);
    idle(3);

    // Strobe at cycle 99 restarts the count.
    strobes(4, 0, 3, 1'b0);
    idle(TO - 2);
    step(1'b1, 0, 3, 1'b1);
    lit("refresh_greater", int'(stable_greater), 1);
    idle(TO - 1);
    lit("refresh_still_locked", int'(stable_valid), 1);
    idle(1);
    lit("refresh_timeout", int'(stable_valid), 0);

    // Strobe on the would-be expiry cycle wins.
    strobes(4, 0, 3, 1'b0);
    idle(TO - 1);
    step(1'b1, 0, 3, 1'b0);
    idle(1);
    lit("sample_wins_valid", int'(stable_valid), 1);

    // Async reset mid-candidate discards it.
    strobes(2, 4, 4, 1'b0);
    reset_n = 1'b0;
    #1;
    lit("async_reset_valid", int'(stable_valid), 0);
    step(1'b1, 4, 4, 1'b0);
    reset_n = 1'b1;
    strobes(2, 4, 4, 1'b0);
    lit("discarded_cand", int'(stable_valid), 0);
    strobes(2, 4, 4, 1'b0);
    lit("relock_name", int'(stable_name), 4);

    // Adjacent-semitone candidates: A4 -> A#4, then B4 -> C5.
    strobes(4, 9, 4, 1'b0);
    strobes(4, 10, 4, 1'b0);
`ifdef NOTE_TRACKER_HYST_EN
    lit("hyst_ais_held", int'(stable_name), 9);
    strobes(4, 10, 4, 1'b0);
`endif
    lit("ais_name", int'(stable_name), 10);
    lit("ais_change", int'(note_change), 1);
    strobes(4, 12, 0, 1'b0);
    strobes(4, 11, 4, 1'b0);
    strobes(4, 0, 5, 1'b1);
`ifdef NOTE_TRACKER_HYST_EN
    lit("hyst_c5_held", int'(stable_octave), 4);
    strobes(4, 0, 5, 1'b1);
`endif
    lit("c5_name", int'(stable_name), 0);
    lit("c5_oct", int'(stable_octave), 5);
    lit("c5_change", int'(note_change), 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
